dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of two, 4..4096).
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning the number of wait cycles inserted before a response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port memRead_in, input, 1 bit: read request level from the CPU data path.
REQ-006 The block SHALL have port memWrite_in, input, 1 bit: write request level from the CPU data path.
REQ-007 The block SHALL have port address_in, input, 32 bits: byte address (ALU result).
REQ-008 The block SHALL have port writeData_in, input, 32 bits: store data (register rt).
REQ-009 The block SHALL have port readData_out, output, 32 bits: load data, valid while ready_out=1.
REQ-010 The block SHALL have port ready_out, output, 1 bit: one-cycle completion strobe.
REQ-011 The block SHALL have port error_out, output, 1 bit: access fault, valid while ready_out=1 (present only with the REQ-026 macro).

Function
REQ-012 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-013 In IDLE, the block SHALL accept a request when memRead_in or memWrite_in is 1, latching address_in, writeData_in and the request type on that edge.
REQ-014 On acceptance, the block SHALL go to WAIT if WAIT_STATES>0, else directly to RESP.
REQ-015 The WAIT state SHALL last exactly WAIT_STATES cycles, counted by a 4-bit down-counter loaded with WAIT_STATES-1; the block SHALL go to RESP when the counter reaches 0.
REQ-016 RESP SHALL last exactly one cycle with ready_out=1; the block SHALL then return to IDLE unconditionally.
REQ-017 ready_out SHALL rise WAIT_STATES+1 cycles after the accepting edge.
REQ-018 Input changes during WAIT or RESP SHALL be ignored; only latched values are used.
REQ-019 A new request SHALL NOT be accepted in RESP; a request held high through RESP SHALL be accepted again in the following IDLE cycle, and the CPU SHALL drop its request after seeing ready_out.
REQ-020 Word index SHALL be latched address[log2(DEPTH_WORDS)+1:2]; bits [1:0] and the upper bits SHALL be ignored, wrapping modulo DEPTH_WORDS.
REQ-021 A write SHALL commit all 32 bits to the array on the edge that ends RESP.
REQ-022 A read SHALL drive readData_out with the array word during RESP; readData_out SHALL be 0 when ready_out=0.
REQ-023 If memRead_in and memWrite_in are both 1 at acceptance, the access SHALL be a write, and readData_out in RESP SHALL equal the latched write data.

Reset
REQ-024 On reset=0, the block SHALL immediately force state IDLE, counter 0, ready_out 0, readData_out 0, error_out 0, and discard latched request values.
REQ-025 Reset during WAIT or RESP SHALL cancel the access with no array write; array contents SHALL NOT be reset.

Configuration
REQ-026 With DMEM_ALIGN_CHECK_EN defined, error_out SHALL exist and be 1 in RESP when latched address[1:0]!=0 or address >= DEPTH_WORDS*4; on a fault, writes SHALL be suppressed and readData_out SHALL be 0, with latency unchanged.
REQ-027 Without DMEM_ALIGN_CHECK_EN, error_out SHALL be absent and REQ-020 wrapping SHALL apply to all addresses.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), the 32-bit data/address width constant and the counter width constant.
REQ-029 Storage SHALL be one sub-module, dmem_array: synchronous write with one write port, combinational read with one read port, and no reset.

Verification
REQ-030 A bench SHALL check write 0xDEADBEEF to 0x10 with WAIT_STATES=2: ready_out exactly 3 cycles after acceptance, followed by a read of 0x10 returning 0xDEADBEEF.
REQ-031 A bench SHALL check, with WAIT_STATES=0, a read of 0x0 after writing 0x12345678: ready_out one cycle after acceptance and readData_out=0x12345678.
REQ-032 A bench SHALL check, with DEPTH_WORDS=256, a write of 0xA5A5A5A5 to 0x400 followed by a read of 0x0: returns 0xA5A5A5A5 without the macro; with the macro, error_out=1 and word 0 is unchanged.
REQ-033 A bench SHALL check that simultaneous memRead_in=memWrite_in=1 with data 0x0000FFFF to 0x20 gives readData_out=0x0000FFFF in RESP, and that a later read of 0x20 returns 0x0000FFFF.
REQ-034 A bench SHALL check that reset=0 asserted during WAIT of a write of 0x11111111 to 0x8 gives ready_out=0 immediately, and that a post-reset read of 0x8 returns the prior value.
REQ-035 A bench SHALL check that changing address_in from 0x4 to 0x8 during WAIT still completes the access on 0x4.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encoding and width constants for dmem_responder
package dmem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-memory request/response bundle; error_out only with DMEM_ALIGN_CHECK_EN
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              memRead_in;
  logic              memWrite_in;
  logic [DATA_W-1:0] address_in;
  logic [DATA_W-1:0] writeData_in;
  logic [DATA_W-1:0] readData_out;
  logic              ready_out;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              error_out;

  modport master (
    output memRead_in, memWrite_in, address_in, writeData_in,
    input  readData_out, ready_out, error_out
  );
  modport slave (
    input  memRead_in, memWrite_in, address_in, writeData_in,
    output readData_out, ready_out, error_out
  );
`else
  modport master (
    output memRead_in, memWrite_in, address_in, writeData_in,
    input  readData_out, ready_out
  );
  modport slave (
    input  memRead_in, memWrite_in, address_in, writeData_in,
    output readData_out, ready_out
  );
`endif
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: one synchronous write port, one combinational read port, no reset
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_W      = 32,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder (IDLE/WAIT/RESP)
// Optional DMEM_ALIGN_CHECK_EN adds fault detection on misaligned / out-of-range addresses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] RESP = ST_RESP;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata;
  logic              in_resp;
  logic              fault;
  logic              we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.memRead_in || bus.memWrite_in) begin
          // a simultaneous read+write is treated as a write
          write_d = bus.memWrite_in;
          addr_d  = bus.address_in;
          wdata_d = bus.writeData_in;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_resp = (state_q == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  assign fault         = (addr_q[1:0] != 2'b00) || (addr_q >= DATA_W'(DEPTH_WORDS * 4));
  assign bus.error_out = in_resp && fault;
`else
  logic unused_addr_bits;
  assign fault            = 1'b0;
  assign unused_addr_bits = ^{addr_q[DATA_W-1:AW+2], addr_q[1:0]};
`endif

  // commit happens on the edge that leaves RESP
  assign we = in_resp && write_q && !fault;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .raddr (addr_q[AW+1:2]),
    .rdata (rdata)
  );

  assign bus.ready_out    = in_resp;
  assign bus.readData_out = (!in_resp || fault) ? '0 : (write_q ? wdata_q : rdata);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench: index 0 is WAIT_STATES=0, index 1 is WAIT_STATES=2
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        rd_i    [2];
  logic        wr_i    [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdat_i  [2];
  logic        rdy_o   [2];
  logic [31:0] rdata_o [2];
  logic        err_o   [2];

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder_if bus0 ();
  dmem_responder_if bus2 ();

  assign bus0.memRead_in   = rd_i[0];
  assign bus0.memWrite_in  = wr_i[0];
  assign bus0.address_in   = addr_i[0];
  assign bus0.writeData_in = wdat_i[0];
  assign bus2.memRead_in   = rd_i[1];
  assign bus2.memWrite_in  = wr_i[1];
  assign bus2.address_in   = addr_i[1];
  assign bus2.writeData_in = wdat_i[1];
  assign rdy_o[0]   = bus0.ready_out;
  assign rdy_o[1]   = bus2.ready_out;
  assign rdata_o[0] = bus0.readData_out;
  assign rdata_o[1] = bus2.readData_out;
`ifdef DMEM_ALIGN_CHECK_EN
  assign err_o[0] = bus0.error_out;
  assign err_o[1] = bus2.error_out;
`else
  assign err_o[0] = 1'b0;
  assign err_o[1] = 1'b0;
`endif

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_w0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut_w2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one complete access; optional retarget of address/data after the accepting edge
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit chg, input logic [31:0] alt,
                        output logic [31:0] rdat, output int cyc, output logic err);
    logic seen;
    @(negedge clk);
    rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; wdat_i[d] = wd;
    @(posedge clk);
    cyc = 0; rdat = '0; err = 1'b0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (chg && cyc == 1) begin
        addr_i[d] = alt;
        wdat_i[d] = 32'h9999_9999;
      end
      if (rdy_o[d]) begin
        seen = 1'b1;
        rdat = rdata_o[d];
        err  = err_o[d];
      end
    end
    rd_i[d] = 1'b0; wr_i[d] = 1'b0;
    check("ready_seen", 32'(seen), 32'd1);
  endtask

  logic [31:0] rdat;
  int          cyc;
  logic        err;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_i[i] = 1'b0; wr_i[i] = 1'b0; addr_i[i] = '0; wdat_i[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_w0", 32'(rdy_o[0]), 32'd0);
    check("rst_ready_w2", 32'(rdy_o[1]), 32'd0);
    check("rst_rdata_w2", rdata_o[1], 32'd0);
    check("rst_err_w2", 32'(err_o[1]), 32'd0);
    reset = 1'b1;

    access(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, '0, rdat, cyc, err);
    check("w2_write_latency", 32'(cyc), 32'd3);
    @(negedge clk);
    check("w2_idle_rdata_zero", rdata_o[1], 32'd0);
    check("w2_idle_ready_zero", 32'(rdy_o[1]), 32'd0);
    access(1, 1'b1, 1'b0, 32'h10, '0, 1'b0, '0, rdat, cyc, err);
    check("w2_read_latency", 32'(cyc), 32'd3);
    check("w2_read_data", rdat, 32'hDEAD_BEEF);

    access(0, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, '0, rdat, cyc, err);
    check("w0_write_latency", 32'(cyc), 32'd1);
    access(0, 1'b1, 1'b0, 32'h0, '0, 1'b0, '0, rdat, cyc, err);
    check("w0_read_latency", 32'(cyc), 32'd1);
    check("w0_read_data", rdat, 32'h1234_5678);

    access(1, 1'b0, 1'b1, 32'h0, 32'h0102_0304, 1'b0, '0, rdat, cyc, err);
    access(1, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0, '0, rdat, cyc, err);
    check("oob_write_latency", 32'(cyc), 32'd3);
    access(1, 1'b1, 1'b0, 32'h0, '0, 1'b0, '0, rdat, cyc, err);
    check("word0_read_err", 32'(err), 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    access(1, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0, '0, rdat, cyc, err);
    check("oob_write_err", 32'(err), 32'd1);
    check("oob_write_rdata", rdat, 32'd0);
    access(1, 1'b1, 1'b0, 32'h0, '0, 1'b0, '0, rdat, cyc, err);
    check("word0_unchanged", rdat, 32'h0102_0304);
    access(1, 1'b1, 1'b0, 32'h11, '0, 1'b0, '0, rdat, cyc, err);
    check("misaligned_err", 32'(err), 32'd1);
`else
    check("word0_wrapped", rdat, 32'hA5A5_A5A5);
`endif

    access(1, 1'b1, 1'b1, 32'h20, 32'h0000_FFFF, 1'b0, '0, rdat, cyc, err);
    check("rw_both_resp_data", rdat, 32'h0000_FFFF);
    access(1, 1'b1, 1'b0, 32'h20, '0, 1'b0, '0, rdat, cyc, err);
    check("rw_both_readback", rdat, 32'h0000_FFFF);

    access(1, 1'b0, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b0, '0, rdat, cyc, err);
    @(negedge clk);
    wr_i[1] = 1'b1; addr_i[1] = 32'h8; wdat_i[1] = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait_ready", 32'(rdy_o[1]), 32'd0);
    check("rst_wait_rdata", rdata_o[1], 32'd0);
    wr_i[1] = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_hold_ready", 32'(rdy_o[1]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    access(1, 1'b1, 1'b0, 32'h8, '0, 1'b0, '0, rdat, cyc, err);
    check("rst_no_write", rdat, 32'hCAFE_F00D);

    access(1, 1'b0, 1'b1, 32'h4, 32'h4444_4444, 1'b1, 32'h8, rdat, cyc, err);
    check("chg_latency", 32'(cyc), 32'd3);
    access(1, 1'b1, 1'b0, 32'h4, '0, 1'b0, '0, rdat, cyc, err);
    check("chg_latched_addr", rdat, 32'h4444_4444);
    access(1, 1'b1, 1'b0, 32'h8, '0, 1'b0, '0, rdat, cyc, err);
    check("chg_other_untouched", rdat, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
